exc_ctrl: RTL

Exception sequencer that sits directly upstream of the CP0 register file in the 5-stage pipeline. It collects exception sources:
- overflow from EX
- `syscall`/`eret` decode from ID
- external interrupt lines

It prioritises them and issues one-cycle write commands for CP0 EPC/Cause/Status. It also flushes the younger pipeline stages and redirects fetch, either to the handler vector or back to EPC.

---
 rtl/cp0_pkg.sv | 25 ++
 rtl/irq_sync.sv | 23 ++
 rtl/exc_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: cp0 op encodings, exception codes, register indices and
// the exception sequencer state type.
package cp0_pkg;

  localparam logic [2:0] OP_MFC0    = 3'b001;
  localparam logic [2:0] OP_MTC0    = 3'b010;
  localparam logic [2:0] OP_SYSCALL = 3'b011;
  localparam logic [2:0] OP_ERET    = 3'b100;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_OV  = 5'd12;

  // CP0 register indices encoded as {cs, sel}
  localparam logic [7:0] CP0_EPC    = 8'd112;
  localparam logic [7:0] CP0_CAUSE  = 8'd104;
  localparam logic [7:0] CP0_STATUS = 8'd96;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    DRAIN
  } exc_state_e;

endpackage

// File: rtl/irq_sync.sv
// Two-flop synchroniser for the external interrupt lines.
module irq_sync #(
  parameter int unsigned WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: prioritises overflow/syscall/eret/interrupt, issues one-cycle
// CP0 write strobes, flushes the pipe, redirects fetch and stalls while it drains.
module exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [2:0]  id_cp0op,
  input  logic [29:0] id_pc,
  input  logic        ex_valid,
  input  logic        ex_ovf,
  input  logic [29:0] ex_pc,
  input  logic [5:0]  irq,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [31:0] epc,
  output logic        epc_we,
  output logic [31:0] epc_wdata,
  output logic        cause_we,
  output logic [4:0]  cause_exccode,
  output logic [5:0]  cause_ip,
  output logic        exl_set,
  output logic        exl_clr,
  output logic        flush,
  output logic        stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  exc_state_e state;
  logic [2:0] cnt;
  logic [5:0] irq_s;
  logic       ovf_req, sys_req, eret_req, irq_req, any_req;

  irq_sync #(
    .WIDTH(6)
  ) u_irq_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (irq),
    .q    (irq_s)
  );

  always_comb begin
    ovf_req  = ex_valid & ex_ovf;
    sys_req  = id_valid & (id_cp0op == OP_SYSCALL);
    eret_req = id_valid & (id_cp0op == OP_ERET);
    irq_req  = (|irq_s) & status_ie & ~status_exl & id_valid;
    any_req  = ovf_req | sys_req | eret_req | irq_req;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      epc_we         <= 1'b0;
      epc_wdata      <= '0;
      cause_we       <= 1'b0;
      cause_exccode  <= '0;
      cause_ip       <= '0;
      exl_set        <= 1'b0;
      exl_clr        <= 1'b0;
      flush          <= 1'b0;
      stall          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      // Strobes are single-cycle; only the IDLE branch raises them.
      epc_we         <= 1'b0;
      cause_we       <= 1'b0;
      exl_set        <= 1'b0;
      exl_clr        <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state          <= COMMIT;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            if (eret_req && !ovf_req && !sys_req) begin
              exl_clr     <= 1'b1;
              redirect_pc <= epc;
            end else begin
              cause_we    <= 1'b1;
              exl_set     <= 1'b1;
              // Nested exceptions keep the original return address.
              epc_we      <= ~status_exl;
              cause_ip    <= irq_s;
              redirect_pc <= EXC_VECTOR;
              if (ovf_req) begin
                epc_wdata     <= {ex_pc, 2'b00};
                cause_exccode <= EXC_OV;
              end else if (sys_req) begin
                epc_wdata     <= {id_pc, 2'b00};
                cause_exccode <= EXC_SYS;
              end else begin
                epc_wdata     <= {id_pc, 2'b00};
                cause_exccode <= EXC_INT;
              end
            end
          end
        end
        COMMIT: begin
          state <= DRAIN;
          stall <= 1'b1;
          cnt   <= 3'(DRAIN_CYCLES);
        end
        DRAIN: begin
          if (cnt <= 3'd1) begin
            state <= IDLE;
            stall <= 1'b0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
